// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and a registered mispredict redirect.
// Optional BP_STATS_EN adds branch and mispredict counters (stat_br, stat_miss).
module branch_predictor #(
    parameter int unsigned IDX_W = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_pc,
    output logic        flush,
    output logic [31:0] flush_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_br,
    output logic [31:0] stat_miss
`endif
);

    localparam int unsigned NUM_ENT = 1 << IDX_W;
    localparam int unsigned TAG_W   = 30 - IDX_W;

    logic [NUM_ENT-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [NUM_ENT];
    logic [31:0]        target_q [NUM_ENT];
    logic [1:0]         ctr_q    [NUM_ENT];

    logic               flush_q;
    logic [31:0]        flush_pc_q;

    logic [IDX_W-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0]   f_tag, u_tag;
    logic               u_hit, u_alloc, mispredict;
    logic [1:0]         ctr_nxt;
    logic [31:0]        correct_pc;

    // Lookup reads the arrays before any same-cycle write lands.
    always_comb begin
        f_idx      = fetch_pc[IDX_W+1:2];
        f_tag      = fetch_pc[31:IDX_W+2];
        pred_taken = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];
        pred_pc    = pred_taken ? target_q[f_idx] : fetch_pc + 32'd4;
    end

    always_comb begin
        u_idx      = upd_pc[IDX_W+1:2];
        u_tag      = upd_pc[31:IDX_W+2];
        u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_alloc    = !u_hit && upd_taken;
        correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;
        // The carried direction bit is implied by upd_pred_pc; only the PC decides.
        mispredict = upd_valid && (correct_pc != upd_pred_pc) && (upd_pred_taken | 1'b1);
        ctr_nxt    = ctr_q[u_idx];
        if (upd_taken) begin
            if (ctr_q[u_idx] != 2'd3) ctr_nxt = ctr_q[u_idx] + 2'd1;
        end else begin
            if (ctr_q[u_idx] != 2'd0) ctr_nxt = ctr_q[u_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q    <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= 32'd0;
        end else begin
            if (upd_valid && u_alloc) valid_q[u_idx] <= 1'b1;
            flush_q <= mispredict;
            if (mispredict) flush_pc_q <= correct_pc;
        end
    end

    // Payload arrays carry no reset; an entry is only meaningful while its valid bit is set.
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_nxt;
                if (upd_taken) target_q[u_idx] <= upd_target;
            end else if (upd_taken) begin
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                ctr_q[u_idx]    <= 2'd2;
            end
        end
    end

    assign flush    = flush_q;
    assign flush_pc = flush_pc_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_miss_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_br_q   <= 32'd0;
            stat_miss_q <= 32'd0;
        end else begin
            if (upd_valid)  stat_br_q   <= stat_br_q + 32'd1;
            if (mispredict) stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign stat_br   = stat_br_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// against an entry-table reference model.
module tb_branch_predictor;

    localparam int IDX_W = 5;
    localparam int NENT  = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_pc;
    logic        flush;
    logic [31:0] flush_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_miss;
`endif

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_pc    (upd_pred_pc),
        .flush          (flush),
        .flush_pc       (flush_pc)
`ifdef BP_STATS_EN
        ,
        .stat_br        (stat_br),
        .stat_miss      (stat_miss)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one record per entry, counter kept as a plain integer.
    bit          m_valid [NENT];
    logic [31:0] m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    bit          exp_flush;
    logic [31:0] exp_flush_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output bit t,
                                       output logic [31:0] npc);
        int i;
        i   = idx_of(pc);
        t   = m_valid[i] && (m_tag[i] == (pc >> (IDX_W + 2))) && (m_ctr[i] >= 2);
        npc = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
        exp_flush    = 1'b0;
        exp_flush_pc = 32'd0;
    endtask

    task automatic model_update(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                                input logic [31:0] ppc);
        int i;
        logic [31:0] correct;
        i       = idx_of(pc);
        correct = t ? tgt : pc + 32'd4;
        exp_flush = (correct != ppc);
        if (exp_flush) exp_flush_pc = correct;
        if (m_valid[i] && m_tag[i] == (pc >> (IDX_W + 2))) begin
            m_ctr[i] = t ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (t) m_tgt[i] = tgt;
        end else if (t) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc >> (IDX_W + 2);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
        end
    endtask

    // One clock: drive at negedge, check lookup before the edge, check flush after it.
    task automatic cycle(input bit uv, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input logic [31:0] uppc,
                         input logic [31:0] fpc);
        bit          et;
        logic [31:0] epc;
        @(negedge clk);
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_pred_pc    = uppc;
        upd_pred_taken = (uppc != upc + 32'd4);
        fetch_pc       = fpc;
        #1;
        model_pred(fpc, et, epc);
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, et});
        chk("pred_pc", pred_pc, epc);
        @(posedge clk);
        if (uv) model_update(upc, ut, utgt, uppc);
        else exp_flush = 1'b0;
        #1;
        chk("flush", {31'd0, flush}, {31'd0, exp_flush});
        chk("flush_pc", flush_pc, exp_flush_pc);
        upd_valid = 1'b0;
    endtask

    // Resolve a branch with the prediction the model says fetch would have made.
    task automatic resolve(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                           input logic [31:0] fpc);
        bit          pt;
        logic [31:0] ppc;
        model_pred(pc, pt, ppc);
        cycle(1'b1, pc, t, tgt, ppc, fpc);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h1C00_0000 | (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        rstn = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_pc = '0; fetch_pc = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Cold lookup
        fetch_pc = 32'h1C00_0000;
        #1;
        chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset_pred_pc", pred_pc, 32'h1C00_0004);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_flush_pc", flush_pc, 32'd0);

        // First taken branch allocates and redirects
        cycle(1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100, 32'h1C00_0014, 32'h1C00_0000);
        chk("alloc_flush", {31'd0, flush}, 32'd1);
        chk("alloc_flush_pc", flush_pc, 32'h1C00_0100);
        cycle(1'b0, '0, 1'b0, '0, '0, 32'h1C00_0010);
        chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("alloc_pred_pc", pred_pc, 32'h1C00_0100);

        // Saturation: 3 taken then 4 not-taken on one PC
        for (int k = 0; k < 3; k++) resolve(32'h1C00_0200, 1'b1, 32'h1C00_0800, 32'h1C00_0200);
        resolve(32'h1C00_0200, 1'b0, 32'h1C00_0800, 32'h1C00_0200);
        chk("sat_nt1_flush", {31'd0, flush}, 32'd1);
        cycle(1'b0, '0, 1'b0, '0, '0, 32'h1C00_0200);
        chk("sat_nt1_still_taken", {31'd0, pred_taken}, 32'd1);
        resolve(32'h1C00_0200, 1'b0, 32'h1C00_0800, 32'h1C00_0200);
        cycle(1'b0, '0, 1'b0, '0, '0, 32'h1C00_0200);
        chk("sat_nt2_not_taken", {31'd0, pred_taken}, 32'd0);
        for (int k = 0; k < 2; k++) resolve(32'h1C00_0200, 1'b0, 32'h1C00_0800, 32'h1C00_0200);
        chk("sat_nt4_no_flush", {31'd0, flush}, 32'd0);

        // Aliasing replaces the entry
        resolve(32'h1C00_0090, 1'b1, 32'h1C00_0400, 32'h1C00_0010);
        cycle(1'b0, '0, 1'b0, '0, '0, 32'h1C00_0010);
        chk("alias_old_pc", {31'd0, pred_taken}, 32'd0);
        cycle(1'b0, '0, 1'b0, '0, '0, 32'h1C00_0090);
        chk("alias_new_pc", pred_pc, 32'h1C00_0400);

        // Same-cycle lookup and update: model check inside cycle sees pre-update state
        resolve(32'h1C00_0300, 1'b1, 32'h1C00_0A00, 32'h1C00_0300);
        cycle(1'b0, '0, 1'b0, '0, '0, 32'h1C00_0300);
        chk("same_cycle_next", {31'd0, pred_taken}, 32'd1);

        // Reset right after a mispredict
        resolve(32'h1C00_0014, 1'b1, 32'h1C00_0C00, 32'h1C00_0000);
        chk("pre_reset_flush", {31'd0, flush}, 32'd1);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        chk("async_flush_drop", {31'd0, flush}, 32'd0);
        chk("async_flush_pc", flush_pc, 32'd0);
        upd_valid = 1'b1; upd_pc = 32'h1C00_0020; upd_taken = 1'b1; upd_target = 32'h1C00_0E00;
        @(posedge clk);
        #1 upd_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < NENT; i++) begin
            fetch_pc = 32'h1C00_0000 + 32'(i * 4);
            #1;
            chk("post_reset_invalid", {31'd0, pred_taken}, 32'd0);
        end
        cycle(1'b0, '0, 1'b0, '0, '0, 32'h1C00_0020);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            logic [31:0] tgt;
            pc  = rand_pc();
            tgt = 32'h1C00_0000 | (32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 3) == 0) begin
                cycle(1'b0, pc, 1'b0, tgt, '0, rand_pc());
            end else if ($urandom_range(0, 4) == 0) begin
                cycle(1'b1, pc, 1'($urandom_range(0, 1)), tgt, rand_pc(), rand_pc());
            end else begin
                resolve(pc, ($urandom_range(0, 2) != 0), tgt, rand_pc());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
